// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its HI/LO pair.
//
// Hazard-unit contract on busy:
//   - While busy=1 the unit ignores start, so the hazard unit must stall
//     MFHI, MFLO, MTHI, MTLO and any MULT/DIV in ID/EX until busy=0.
//   - HI/LO written at edge E become visible in the cycle after E.
//     There is no bypass, so an MFHI/MFLO issued into that same edge
//     reads the old value.
//   - flush aborts an iterative op at the next edge and leaves HI/LO
//     untouched.
package mdu_pkg;

  localparam int DATA_W    = 32;
  localparam int MDU_ITERS = 32;
  localparam int CNT_W     = $clog2(MDU_ITERS);

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } mdu_state_e;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run 32 shift-add / restoring-divide steps on operand
// magnitudes, followed by one sign-fix cycle, for 33 cycles in total.
// MTHI/MTLO write in a single cycle.
//
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   start, op     request and operation code (mdu_op_e; 6-7 are no-ops)
//   src_a, src_b  rs / rt operands
//   flush         aborts an op in flight and drops a same-cycle request
//   busy          high while an iterative op occupies the unit
//   done          one-cycle pulse after HI/LO are written
//   hi, lo        HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;       // product, or remainder:quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;  // negate product / quotient
  logic             neg_rem_q, neg_rem_d;  // remainder follows sign of src_a
  logic             is_div_q, is_div_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Operand decode for an incoming request.
  logic             signed_op, is_div_op, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div_op = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign sign_a    = signed_op & src_a[WIDTH-1];
  assign sign_b    = signed_op & src_b[WIDTH-1];
  assign mag_a     = cond_neg(src_a, sign_a);
  assign mag_b     = cond_neg(src_b, sign_b);

  // One multiply step: add multiplicand into the upper half when the
  // multiplier bit in acc[0] is set; the carry is kept for the right shift.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};

  // One restoring-divide step: the remainder shifted left by one can reach
  // 33 bits, so compare at that width; a passing difference fits in 32 bits.
  logic [WIDTH:0]   rem_sh;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_diff;
  assign rem_sh     = acc_q[AW-1:WIDTH-1];
  assign trial_ge   = rem_sh >= {1'b0, opnd_q};
  assign trial_diff = rem_sh[WIDTH-1:0] - opnd_q;

  // Sign correction applied in FIX. With a zero divisor the remainder is
  // |src_a|, so restoring the sign of src_a returns src_a itself.
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = div_zero_q ? '1 : cond_neg(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix  = cond_neg(acc_q[AW-1:WIDTH], neg_rem_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d    = ST_CALC;
              cnt_d      = '0;
              is_div_d   = is_div_op;
              neg_res_d  = sign_a ^ sign_b;
              neg_rem_d  = sign_a;
              div_zero_d = is_div_op && (src_b == '0);
              acc_d      = is_div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
              opnd_d     = is_div_op ? mag_b : mag_a;
            end
            MDU_MTHI: begin
              hi_d   = src_a;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = src_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          acc_d = trial_ge ? {trial_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[AW-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[AW-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MDU_ITERS - 1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush beats everything, including a same-cycle MTHI/MTLO and the FIX write.
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases, flush/reset behaviour,
// and randomized MULT/MULTU/DIV/DIVU against an arithmetic reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference model: plain 64-bit arithmetic; SV signed division truncates
  // toward zero and the remainder follows the dividend, as MIPS requires.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    h = '0;
    l = '0;
    if (o == MDU_MULT) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (o == MDU_MULTU) begin
      p = ua * ub;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (o == MDU_DIV) begin
      p = sa / sb;
      l = p[31:0];
      p = sa % sb;
      h = p[31:0];
    end else begin
      p = ua / ub;
      l = p[31:0];
      p = ua % ub;
      h = p[31:0];
    end
  endfunction

  // Issue one iterative op, track busy cycles and done, check results.
  task automatic run_iter(input string name, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    int early_done = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    while (busy && n < 100) begin
      if (done) early_done++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 33) $display("FAIL %s busy_cycles got %0d want 33", name, n);
    else passed++;
    total++;
    if (early_done !== 0) $display("FAIL %s done_while_busy got %0d want 0", name, early_done);
    else passed++;
    total++;
    if (done !== 1'b1) $display("FAIL %s done got %b want 1", name, done);
    else passed++;
    total++;
    if (hi !== exp_hi) $display("FAIL %s hi got %h want %h", name, hi, exp_hi);
    else passed++;
    total++;
    if (lo !== exp_lo) $display("FAIL %s lo got %h want %h", name, lo, exp_lo);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL %s done_pulse got %b want 0", name, done);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (hi !== 32'd0) $display("FAIL reset hi got %h want 0", hi); else passed++;
    total++;
    if (lo !== 32'd0) $display("FAIL reset lo got %h want 0", lo); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset done got %b want 0", done); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_iter("mult_neg3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_iter("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_iter("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_iter("divu_by0", MDU_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_iter("div_neg_by0", MDU_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    run_iter("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_iter("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_mt();
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; src_a = 32'hAAAA_0000;
    @(negedge clk);
    op = MDU_MTLO; src_a = 32'h0000_5555;
    total++;
    if (hi !== 32'hAAAA_0000) $display("FAIL mthi hi got %h want aaaa0000", hi); else passed++;
    total++;
    if (done !== 1'b1) $display("FAIL mthi done got %b want 1", done); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL mthi busy got %b want 0", busy); else passed++;
    @(negedge clk);
    op = 3'd6; src_a = 32'h1111_2222;
    total++;
    if (lo !== 32'h0000_5555) $display("FAIL mtlo lo got %h want 00005555", lo); else passed++;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0) $display("FAIL noop done got %b want 0", done); else passed++;
    total++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555)
      $display("FAIL noop hilo got %h/%h want aaaa0000/00005555", hi, lo);
    else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; src_a = 32'd1234; src_b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = MDU_MTLO; src_a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (lo !== 32'h0000_5555) $display("FAIL mtlo_busy lo got %h want 00005555", lo); else passed++;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL mtlo_busy busy/done got %b/%b want 1/0", busy, done);
    else passed++;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL flush busy got %b want 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL flush done got %b want 0", done); else passed++;
    total++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555)
      $display("FAIL flush hilo got %h/%h want aaaa0000/00005555", hi, lo);
    else passed++;
    start = 1'b1; flush = 1'b1; op = MDU_MTHI; src_a = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    total++;
    if (hi !== 32'hAAAA_0000 || done !== 1'b0)
      $display("FAIL flush_start hi/done got %h/%b want aaaa0000/0", hi, done);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL flush_idle busy/done got %b/%b want 0/0", busy, done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] eh, el;
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL rst_mid hilo got %h/%h want 0/0", hi, lo);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid busy/done got %b/%b want 0/0", busy, done);
    else passed++;
    rst_n = 1'b1;
    ref_op(MDU_MULT, 32'd123, 32'hFFFF_FFFB, eh, el);
    run_iter("mult_after_rst", MDU_MULT, 32'd123, 32'hFFFF_FFFB, eh, el);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_op(o, a, b, eh, el);
      run_iter($sformatf("rand%0d_op%0d", i, o), o, a, b, eh, el);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mt();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog: every wait above is bounded, this only guards against a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair for the pipelined MIPS core. It sits in the EX stage as the consumer of the selected ALU operands. It executes MULT/MULTU/DIV/DIVU over 33 cycles and MTHI/MTLO in one cycle. It drives `busy` so the hazard unit can stall MFHI/MFLO and further MDU ops.

## Interface

Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0 and `flush`=0.
- `op`  in  3  operation code (`mdu_pkg`): 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- `src_a`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- `src_b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `busy`  out  1  high while an iterative op is in flight.
- `done`  out  1  one-cycle pulse after HI/LO are written.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- Reset (`rst_n`=0 at an edge): state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter=0.
- States:
  - IDLE: on accepted MULT/MULTU/DIV/DIVU, latch operand magnitudes and result signs, then go to CALC with counter=0. On accepted MTHI/MTLO, write `hi`/`lo` from `src_a` and stay in IDLE. Ops 6–7 do nothing and produce no `done`.
  - CALC: 32 iterations, one per cycle. Multiply uses shift-add on a 64-bit accumulator. Divide uses restoring division: shift remainder:quotient left, trial-subtract divisor, set quotient bit when the result is ≥0. Go to FIX when counter=31.
  - FIX: apply sign correction and write HI/LO, then return to IDLE.
- Signed handling (MULT, DIV): operate on `|src_a|`, `|src_b|`.
  - Product is negated (64-bit two's complement) if the sign of `src_a` differs from the sign of `src_b`.
  - Quotient is negated on the same condition.
  - Remainder takes the sign of `src_a`.
- Results: mult writes `hi`=product[63:32], `lo`=product[31:0]. Div writes `lo`=quotient, `hi`=remainder.
- Divide by zero (DIV or DIVU, `src_b`=0): still takes the full latency. Result is `lo`=32'hFFFFFFFF, `hi`=`src_a`, with no sign correction.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `lo`=0x80000000, `hi`=0. This falls out of magnitude arithmetic with 32-bit wrap.
- `start` while `busy`=1 is ignored; upstream must stall.
- `flush`: at the next edge, go to IDLE with `busy`=0. `hi`/`lo` are unchanged and no `done` is produced. If `flush` and `start` are high in the same cycle, `flush` wins and the request is dropped, including MTHI/MTLO.
- Reset mid-operation: immediate return to reset values at the edge; no `done`.

## Timing

- Iterative op accepted at edge E0: `busy`=1 from E0 through E33 and drops at E33.
  - CALC occupies E1–E32; FIX is E33.
  - `hi`/`lo` update at E33, and `done`=1 for the cycle after E33.
  - Latency is 33 cycles; a new `start` can be accepted at E33 (back-to-back).
- MTHI/MTLO accepted at E0: register is written at E0, `done`=1 for the following cycle, `busy` stays 0.
- `hi`/`lo` are registered outputs. A value written at edge E is readable in the cycle after E; there is no internal bypass of a concurrent write.

## Structure

- `mdu_pkg` holds:
  - `op` encodings (`MDU_MULT` … `MDU_MTLO`)
  - state enum (IDLE, CALC, FIX)
  - `MDU_ITERS`=32
  - the hazard-unit contract on `busy`.
- Single module with no sub-module. Datapath: 64-bit accumulator, 32-bit divisor/multiplicand, 5-bit counter, two latched sign bits, and a div-by-zero flag.

## Test plan

- MULT `src_a`=0xFFFFFFFD (−3), `src_b`=7 → at E33 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high exactly 33 cycles; single `done` pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then immediately DIVU 100/7 → `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678 after 33 cycles.
- After MTHI 0xAAAA0000 / MTLO 0x5555, start MULT, then:
  - `flush` at E10 → `busy` drops next edge, no `done`, `hi`/`lo` still 0xAAAA0000/0x5555.
  - MTLO asserted while `busy` → ignored.
- `rst_n`=0 at E20 of a DIV → `hi`=`lo`=0, `busy`=`done`=0 on the next cycle; a new MULT started afterwards completes normally.
